serial_add_ctrl: RTL and testbench

//  Bit-serial adder controller: one shared 1-bit full-adder cell adds two WIDTH-bit operands, LSB first, one bit per clock.
//  FSM sequences the operation; shift registers hold the operands; a carry flip-flop holds the running carry.

---
 rtl/serial_add_ctrl_if.sv | 43 ++++
 rtl/serial_add_ctrl.sv | 144 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
// Host <-> serial adder handshake bundle.
//   start  host -> adder   request; accepted only when the adder is idle/done
//   A, B   host -> adder   WIDTH-bit addends, captured on accepted start
//   Ci     host -> adder   carry-in, captured on accepted start
//   busy   adder -> host   high while the bit-serial add is in progress
//   done   adder -> host   one-cycle pulse, S/Co (and ovf) valid
//   S, Co  adder -> host   registered sum / carry-out, held until next result
//   ovf    adder -> host   two's-complement overflow (only with SERIAL_ADD_OVF_EN)
// Modports: master = host side, slave = adder side.
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Co;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, A, B, Ci,
        input  busy, done, S, Co
`ifdef SERIAL_ADD_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, A, B, Ci,
        output busy, done, S, Co
`ifdef SERIAL_ADD_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder: a single full-adder cell processes the operands LSB first,
// one bit per clock, under control of a three-state FSM (IDLE/SHIFT/DONE).
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (aborts any add in progress)
//   bus    serial_add_ctrl_if.slave: start/A/B/Ci in, busy/done/S/Co out
//
// Parameters
//   WIDTH  operand / sum width (>= 2)
//   CNT_W  bit-counter width, 2**CNT_W > WIDTH
//
// Optional feature macro: SERIAL_ADD_OVF_EN
//   When defined, bus.ovf reports two's-complement overflow of the last add
//   (carry into MSB XOR carry out), registered and held alongside S/Co.
//
// Timing: start sampled at edge k -> WIDTH SHIFT cycles -> done in cycle
// k+WIDTH+1. A start seen in DONE launches the next add immediately.
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;

    logic [WIDTH-1:0] ra_reg;     // operand A, shifted right each SHIFT cycle
    logic [WIDTH-1:0] rb_reg;     // operand B, shifted right each SHIFT cycle
    logic [WIDTH-1:0] rs_reg;     // partial sum, filled from the MSB side
    logic             c_reg;      // running carry
    logic [CNT_W-1:0] cnt_reg;    // bits processed so far
    logic [WIDTH-1:0] s_reg;
    logic             co_reg;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_reg;
`endif

    logic             sum_bit;
    logic             carry_bit;
    logic             accept;
    logic             last_shift;
    logic [WIDTH-1:0] rs_shifted;

    // Shared full-adder cell.
    assign sum_bit   = ra_reg[0] ^ rb_reg[0] ^ c_reg;
    assign carry_bit = (ra_reg[0] & rb_reg[0]) | (c_reg & (ra_reg[0] ^ rb_reg[0]));

    // New sum bit enters at the MSB; after WIDTH shifts the LSB sits at bit 0.
    assign rs_shifted = {sum_bit, rs_reg[WIDTH-1:1]};

    // start is only honoured when no add is in flight.
    assign accept     = bus.start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign last_shift = (state_reg == ST_SHIFT) && (cnt_reg == CNT_W'(WIDTH - 1));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_shift) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = accept ? ST_SHIFT : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, serial shift, result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_reg  <= '0;
            rb_reg  <= '0;
            rs_reg  <= '0;
            c_reg   <= 1'b0;
            cnt_reg <= '0;
            s_reg   <= '0;
            co_reg  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_reg <= 1'b0;
`endif
        end else if (accept) begin
            ra_reg  <= bus.A;
            rb_reg  <= bus.B;
            c_reg   <= bus.Ci;
            rs_reg  <= '0;
            cnt_reg <= '0;
        end else if (state_reg == ST_SHIFT) begin
            ra_reg  <= ra_reg >> 1;
            rb_reg  <= rb_reg >> 1;
            rs_reg  <= rs_shifted;
            c_reg   <= carry_bit;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (last_shift) begin
                s_reg  <= rs_shifted;
                co_reg <= carry_bit;
`ifdef SERIAL_ADD_OVF_EN
                // On the MSB cycle c_reg is the carry into the MSB.
                ovf_reg <= c_reg ^ carry_bit;
`endif
            end
        end
    end

    // Outputs decode straight from registered state, so no glitches.
    assign bus.busy = (state_reg == ST_SHIFT);
    assign bus.done = (state_reg == ST_DONE);
    assign bus.S    = s_reg;
    assign bus.Co   = co_reg;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Scoreboard bench for serial_add_ctrl. The driver pushes the expected result
// (value and completion cycle) when it issues a start; an independent monitor
// pops and compares whenever done is seen, and checks S/Co hold otherwise.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int W     = 4;
    localparam int CNT_W = 3;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
        int           cyc;
        string        name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   failed;

    exp_t         sb[$];
    logic [W-1:0] held_s;
    logic         held_co;
    logic         held_ovf;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(
        .WIDTH (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        exp_t   e;
        longint u;
        longint sa;
        longint sb_v;
        longint sv;
        u    = longint'(a) + longint'(b) + longint'(ci);
        e.s  = u[W-1:0];
        e.co = u[W];
        sa   = (a >= W'(2**(W-1))) ? longint'(a) - longint'(2**W) : longint'(a);
        sb_v = (b >= W'(2**(W-1))) ? longint'(b) - longint'(2**W) : longint'(b);
        sv   = sa + sb_v + longint'(ci);
        e.ovf = (sv > longint'(2**(W-1) - 1)) || (sv < -longint'(2**(W-1)));
        e.cyc = 0;
        e.name = "";
        return e;
    endfunction

    // Issue one add at the current negedge, then ride out the busy period.
    // mode 0: start low while busy, 1: random start pulses, 2: start held high.
    // Returns at the negedge of the DONE cycle with start=0 (caller may override).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic [W-1:0] es, input logic eco, input logic eovf,
                          input string nm, input int mode);
        exp_t e;
        e.s = es; e.co = eco; e.ovf = eovf; e.name = nm;
        e.cyc = cyc + 1 + W;
        sb.push_back(e);
        bus.A = a; bus.B = b; bus.Ci = ci; bus.start = 1'b1;
        repeat (W) begin
            @(negedge clk);
            bus.A  = W'($urandom);
            bus.B  = W'($urandom);
            bus.Ci = 1'($urandom);
            case (mode)
                0:       bus.start = 1'b0;
                1:       bus.start = 1'($urandom);
                default: bus.start = 1'b1;
            endcase
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Monitor / scoreboard checker.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_done_exclusive", {31'd0, bus.busy & bus.done}, 32'd0);
            if (sb.size() == 0) chk("idle_busy", {31'd0, bus.busy}, 32'd0);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", {31'd0, bus.done}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_S"},  32'(bus.S),  32'(e.s));
                    chk({e.name, "_Co"}, 32'(bus.Co), 32'(e.co));
`ifdef SERIAL_ADD_OVF_EN
                    chk({e.name, "_ovf"}, 32'(bus.ovf), 32'(e.ovf));
`endif
                    chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
                    $display("[TB] %s: S=%0h Co=%0b at cycle %0d", e.name, bus.S, bus.Co, cyc);
                    held_s   = e.s;
                    held_co  = e.co;
                    held_ovf = e.ovf;
                end
            end else begin
                chk("hold_S",  32'(bus.S),  32'(held_s));
                chk("hold_Co", 32'(bus.Co), 32'(held_co));
`ifdef SERIAL_ADD_OVF_EN
                chk("hold_ovf", 32'(bus.ovf), 32'(held_ovf));
`endif
            end
        end
    end

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
        chk({nm, "_done"}, 32'(bus.done), 32'd0);
        chk({nm, "_S"},    32'(bus.S),    32'd0);
        chk({nm, "_Co"},   32'(bus.Co),   32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk({nm, "_ovf"},  32'(bus.ovf),  32'd0);
`endif
    endtask

    initial begin
        exp_t e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        tests = 0; failed = 0;
        held_s = '0; held_co = 1'b0; held_ovf = 1'b0;

        // Reset with random inputs toggling.
        rst_n = 1'b0;
        repeat (4) begin
            bus.start = 1'($urandom); bus.A = W'($urandom);
            bus.B = W'($urandom); bus.Ci = 1'($urandom);
            @(negedge clk);
            chk_reset_outputs("reset");
        end
        bus.start = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);   // monitor confirms no activity

        // Directed cases (expected values taken from hand arithmetic).
        run_op(4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b1, "add_5_3_0", 0);
        repeat (3) @(negedge clk);
        run_op(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, "add_F_F_1", 1);
        repeat (8) @(negedge clk);   // result must hold
        run_op(4'h7, 4'h9, 1'b0, 4'h0, 1'b1, 1'b0, "b2b_7_9_0", 2);
        run_op(4'h2, 4'h2, 1'b1, 4'h5, 1'b0, 1'b0, "b2b_2_2_1", 2);
        repeat (3) @(negedge clk);

        // Reset abort during the second SHIFT cycle.
        e.s = '0; e.co = 1'b0; e.ovf = 1'b0; e.cyc = 0; e.name = "aborted";
        sb.push_back(e);
        bus.A = 4'h6; bus.B = 4'h1; bus.Ci = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        held_s = '0; held_co = 1'b0; held_ovf = 1'b0;
        #1;
        chk_reset_outputs("abort");
        repeat (2) @(negedge clk);
        chk_reset_outputs("abort_hold");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);   // no late done allowed
        run_op(4'hA, 4'h3, 1'b1, 4'hE, 1'b0, 1'b0, "post_reset_A_3_1", 0);
        repeat (2) @(negedge clk);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            ci = 1'($urandom);
            e  = model(a, b, ci);
            run_op(a, b, ci, e.s, e.co, e.ovf, $sformatf("rnd%0d", i), $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
